c1541_track_ctrl: RTL and testbench

Track-buffer sequencer for the 1541 drive. It sits between the head stepper, the GCR encoder/decoder and the SD block bridge. It loads the current D64 track into the track buffer RAM one 256-byte sector at a time. It tracks which sectors the GCR engine has written and writes those back before the head leaves the track or the motor stops. While the buffer is being moved it holds `ram_ready` low so the GCR engine stays idle.

---
 rtl/c1541_track_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_c1541_track_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1541_track_ctrl.sv
// Track-buffer sequencer for the 1541 drive. It loads D64 tracks into the buffer RAM one sector at a time.
// Defining C1541_WRITEBACK_EN adds dirty-sector tracking and the write-back (flush) path.
module c1541_track_ctrl #(
    parameter int SETTLE_CYC = 32000
) (
    input  logic       clk32,
    input  logic       reset,
    input  logic [5:0] track_req,
    input  logic       mtr,
    input  logic       img_mounted,
    input  logic       img_readonly,
    input  logic       gcr_we,
    input  logic [4:0] gcr_sector,
    output logic [5:0] track,
    output logic       ram_ready,
    output logic [4:0] buf_sector,
    output logic [9:0] sd_lba,
    output logic       sd_rd,
    output logic       sd_wr,
    input  logic       sd_ack
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SETTLE     = 3'd1;
`ifdef C1541_WRITEBACK_EN
    localparam logic [2:0] S_FLUSH_SCAN = 3'd2;
    localparam logic [2:0] S_FLUSH_REQ  = 3'd3;
    localparam logic [2:0] S_FLUSH_WAIT = 3'd4;
`endif
    localparam logic [2:0] S_LOAD_REQ   = 3'd5;
    localparam logic [2:0] S_LOAD_WAIT  = 3'd6;
    localparam logic [2:0] S_READY      = 3'd7;

    function automatic logic [4:0] track_nsec(input logic [5:0] t);
        if (t <= 6'd17)      return 5'd21;
        else if (t <= 6'd24) return 5'd19;
        else if (t <= 6'd30) return 5'd18;
        else                 return 5'd17;
    endfunction

    function automatic logic [9:0] track_base(input logic [5:0] t);
        logic [9:0] tw;
        tw = {4'b0000, t};
        if (t == 6'd0 || t > 6'd35) return 10'd0;
        else if (t <= 6'd17)        return (tw - 10'd1) * 10'd21;
        else if (t <= 6'd24)        return 10'd357 + (tw - 10'd18) * 10'd19;
        else if (t <= 6'd30)        return 10'd490 + (tw - 10'd25) * 10'd18;
        else                        return 10'd598 + (tw - 10'd31) * 10'd17;
    endfunction

    function automatic logic on_image(input logic [5:0] t);
        return (t >= 6'd1) && (t <= 6'd35);
    endfunction

    logic [2:0]       state;
    logic             loaded;
    logic             ack_seen;
    logic             mount_pend;
    logic [5:0]       req_q;
    logic [CNT_W-1:0] settle_cnt;
    logic             settled;

    // Free-running debounce of track_req, so a brief wobble never disturbs a loaded buffer.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            req_q      <= 6'd0;
            settle_cnt <= '0;
        end else if (track_req != req_q) begin
            // NOTE: state is updated with <= so every flop samples the pre-edge values.
            req_q      <= track_req;
            settle_cnt <= '0;
        end else if (settle_cnt != SETTLE_LAST) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
        end
    end

    assign settled = (track_req == req_q) && (settle_cnt == SETTLE_LAST);

`ifdef C1541_WRITEBACK_EN
    logic [20:0] dirty;
    logic        mtr_q;
    logic        mtr_fall;
    logic        flush_done;

    function automatic logic [4:0] lowest_dirty(input logic [20:0] m);
        lowest_dirty = 5'd0;
        for (int i = 20; i >= 0; i--) begin
            if (m[i]) lowest_dirty = 5'(i);
        end
    endfunction

    assign mtr_fall   = mtr_q && !mtr;
    assign flush_done = (state == S_FLUSH_WAIT) && ack_seen && !sd_ack;

    // NOTE: the dirty mask is a small flop array, so it is cleared by reset rather than left unknown.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            dirty <= '0;
            mtr_q <= 1'b0;
        end else begin
            mtr_q <= mtr;
            if (img_mounted) begin
                dirty <= '0;
            end else begin
                if (flush_done) dirty[buf_sector] <= 1'b0;
                if (state == S_READY && gcr_we && !img_readonly && gcr_sector < 5'd21)
                    dirty[gcr_sector] <= 1'b1;
            end
        end
    end
`else
    logic unused_wb_inputs;
    assign unused_wb_inputs = ^{mtr, img_readonly, gcr_we, gcr_sector};
`endif

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            track      <= 6'd0;
            buf_sector <= 5'd0;
            loaded     <= 1'b0;
            ack_seen   <= 1'b0;
            mount_pend <= 1'b0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
        end else begin
            if (img_mounted) loaded <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (img_mounted || track_req != track) state <= S_SETTLE;
                end

                S_SETTLE: begin
                    // A mount this cycle is decided next cycle, once loaded/dirty are cleared.
                    if (!img_mounted && settled) begin
`ifdef C1541_WRITEBACK_EN
                        if (dirty != '0) state <= S_FLUSH_SCAN;
                        else
`endif
                        if (loaded && req_q == track) begin
                            state <= S_READY;
                        end else begin
                            track      <= req_q;
                            buf_sector <= 5'd0;
                            loaded     <= 1'b0;
                            state      <= on_image(req_q) ? S_LOAD_REQ : S_IDLE;
                        end
                    end
                end

                S_LOAD_REQ: begin
                    if (img_mounted) begin
                        state <= S_SETTLE;
                    end else if (!sd_ack) begin
                        sd_rd    <= 1'b1;
                        ack_seen <= 1'b0;
                        state    <= S_LOAD_WAIT;
                    end
                end

                S_LOAD_WAIT: begin
                    if (img_mounted) mount_pend <= 1'b1;
                    if (!ack_seen) begin
                        if (sd_ack) begin
                            sd_rd    <= 1'b0;
                            ack_seen <= 1'b1;
                        end
                    end else if (!sd_ack) begin
                        mount_pend <= 1'b0;
                        if (img_mounted || mount_pend || track_req != track) begin
                            state <= S_SETTLE;
                        end else if (buf_sector == track_nsec(track) - 5'd1) begin
                            loaded <= 1'b1;
                            state  <= S_READY;
                        end else begin
                            buf_sector <= buf_sector + 5'd1;
                            state      <= S_LOAD_REQ;
                        end
                    end
                end

                S_READY: begin
                    if (img_mounted) state <= S_SETTLE;
`ifdef C1541_WRITEBACK_EN
                    else if (mtr_fall && dirty != '0) state <= S_FLUSH_SCAN;
`endif
                    else if (settled && track_req != track) state <= S_SETTLE;
                end

`ifdef C1541_WRITEBACK_EN
                S_FLUSH_SCAN: begin
                    if (img_mounted) begin
                        state <= S_SETTLE;
                    end else if (dirty != '0) begin
                        buf_sector <= lowest_dirty(dirty);
                        state      <= S_FLUSH_REQ;
                    end else if (loaded && track_req == track) begin
                        state <= S_READY;
                    end else begin
                        // Re-enter SETTLE so an off-image request still ends in IDLE.
                        state <= S_SETTLE;
                    end
                end

                S_FLUSH_REQ: begin
                    if (img_mounted) begin
                        state <= S_SETTLE;
                    end else if (!sd_ack) begin
                        sd_wr    <= 1'b1;
                        ack_seen <= 1'b0;
                        state    <= S_FLUSH_WAIT;
                    end
                end

                S_FLUSH_WAIT: begin
                    if (img_mounted) mount_pend <= 1'b1;
                    if (!ack_seen) begin
                        if (sd_ack) begin
                            sd_wr    <= 1'b0;
                            ack_seen <= 1'b1;
                        end
                    end else if (!sd_ack) begin
                        mount_pend <= 1'b0;
                        state      <= (img_mounted || mount_pend) ? S_SETTLE : S_FLUSH_SCAN;
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

    assign ram_ready = (state == S_READY);
    assign sd_lba    = track_base(track) + {5'b00000, buf_sector};

endmodule

// File: tb/tb_c1541_track_ctrl.sv
// Directed bench for c1541_track_ctrl with a simple SD bridge model that acks 10 cycles after each request.
module tb_c1541_track_ctrl;

    localparam int SETTLE = 8;

    logic       clk32 = 1'b0;
    logic       reset;
    logic [5:0] track_req;
    logic       mtr;
    logic       img_mounted;
    logic       img_readonly;
    logic       gcr_we;
    logic [4:0] gcr_sector;
    logic       sd_ack;
    logic [5:0] track;
    logic       ram_ready;
    logic [4:0] buf_sector;
    logic [9:0] sd_lba;
    logic       sd_rd;
    logic       sd_wr;

    c1541_track_ctrl #(.SETTLE_CYC(SETTLE)) dut (
        .clk32       (clk32),
        .reset       (reset),
        .track_req   (track_req),
        .mtr         (mtr),
        .img_mounted (img_mounted),
        .img_readonly(img_readonly),
        .gcr_we      (gcr_we),
        .gcr_sector  (gcr_sector),
        .track       (track),
        .ram_ready   (ram_ready),
        .buf_sector  (buf_sector),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack)
    );

    always #5 clk32 = ~clk32;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Bridge model: logs every request, checks address stability, then acks.
    int log_lba[$];
    int log_buf[$];
    bit log_wr[$];
    int total_wr = 0;
    int unstable = 0;
    int overlap  = 0;
    int wr_cycles = 0;

    initial begin
        int lba_r;
        int buf_r;
        sd_ack = 1'b0;
        forever begin
            @(negedge clk32);
            if (sd_rd || sd_wr) begin
                lba_r = int'(sd_lba);
                buf_r = int'(buf_sector);
                log_lba.push_back(lba_r);
                log_buf.push_back(buf_r);
                log_wr.push_back(sd_wr);
                if (sd_wr) total_wr++;
                repeat (10) @(negedge clk32);
                sd_ack = 1'b1;
                repeat (4) @(negedge clk32);
                if (int'(sd_lba) != lba_r || int'(buf_sector) != buf_r) unstable++;
                sd_ack = 1'b0;
            end
        end
    end

    always @(negedge clk32) begin
        if (sd_rd && sd_wr) overlap++;
        if (sd_wr) wr_cycles++;
    end

    int exp_lba[$];
    int exp_buf[$];
    bit exp_wr[$];

    task automatic clear_logs();
        log_lba.delete(); log_buf.delete(); log_wr.delete();
        exp_lba.delete(); exp_buf.delete(); exp_wr.delete();
    endtask

    task automatic add_reads(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_lba.push_back(base + i);
            exp_buf.push_back(i);
            exp_wr.push_back(1'b0);
        end
    endtask

    task automatic add_write(input int lba, input int sec);
        exp_lba.push_back(lba);
        exp_buf.push_back(sec);
        exp_wr.push_back(1'b1);
    endtask

    task automatic compare_log(input string tag);
        int n;
        check({tag, "_count"}, log_lba.size(), exp_lba.size());
        n = (log_lba.size() < exp_lba.size()) ? log_lba.size() : exp_lba.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_lba%0d", tag, i), log_lba[i], exp_lba[i]);
            check($sformatf("%s_buf%0d", tag, i), log_buf[i], exp_buf[i]);
            check($sformatf("%s_wr%0d", tag, i), log_wr[i], exp_wr[i]);
        end
    endtask

    task automatic wait_rr(input logic level, input int budget, input string tag);
        int k;
        k = 0;
        while (ram_ready !== level && k < budget) begin
            @(negedge clk32);
            k++;
        end
        check(tag, ram_ready, level);
    endtask

    task automatic pulse_we(input logic [4:0] sec);
        @(negedge clk32);
        gcr_sector = sec;
        gcr_we     = 1'b1;
        @(negedge clk32);
        gcr_we     = 1'b0;
    endtask

    task automatic pulse_mount();
        @(negedge clk32);
        img_mounted = 1'b1;
        @(negedge clk32);
        img_mounted = 1'b0;
    endtask

    task automatic retrack(input logic [5:0] t, input string tag);
        track_req = t;
        wait_rr(1'b0, 100, {tag, "_busy"});
        wait_rr(1'b1, 3000, {tag, "_ready"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int low;
        int k;
        int wr_snap;

        reset = 1'b1; track_req = 6'd18; mtr = 1'b1; img_mounted = 1'b0;
        img_readonly = 1'b0; gcr_we = 1'b0; gcr_sector = 5'd0;
        repeat (3) @(negedge clk32);

        check("rst_track", track, 6'd0);
        check("rst_ram_ready", ram_ready, 1'b0);
        check("rst_sd_rd", sd_rd, 1'b0);
        check("rst_sd_wr", sd_wr, 1'b0);
        check("rst_buf_sector", buf_sector, 5'd0);
        check("rst_sd_lba", sd_lba, 10'd0);

        // Scenario 1: first load of track 18 straight out of reset.
        clear_logs();
        reset = 1'b0;
        lat = 0;
        while (!sd_rd && lat < 200) begin
            @(negedge clk32);
            lat++;
        end
        check("rd_latency", lat, SETTLE + 2);
        wait_rr(1'b1, 3000, "s1_ready");
        check("s1_track", track, 6'd18);
        add_reads(357, 19);
        compare_log("s1");

        // Scenario 2: dirty sectors 3 and 20 on track 1, then step to track 2.
        retrack(6'd1, "s2a");
        check("s2a_track", track, 6'd1);
        clear_logs();
        pulse_we(5'd3);
        pulse_we(5'd20);
        track_req = 6'd2;
        wait_rr(1'b0, 100, "s2_busy");
        pulse_we(5'd9);
        wait_rr(1'b1, 3000, "s2_ready");
        check("s2_track", track, 6'd2);
`ifdef C1541_WRITEBACK_EN
        add_write(3, 3);
        add_write(20, 20);
`endif
        add_reads(21, 21);
        compare_log("s2");

        // Motor stop with a clean buffer: the write while busy must have been ignored.
        clear_logs();
        mtr = 1'b0;
        repeat (60) @(negedge clk32);
        check("s2_mtr_requests", log_lba.size(), 0);
        check("s2_mtr_ready", ram_ready, 1'b1);
        mtr = 1'b1;

        // Scenario 3: short 5->6->5 wobble must not disturb the buffer.
        retrack(6'd5, "s3a");
        clear_logs();
        low = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 0) track_req = 6'd6;
            if (i == 3) track_req = 6'd5;
            @(negedge clk32);
            if (ram_ready !== 1'b1) low++;
        end
        check("s3_ready_low_cycles", low, 0);
        check("s3_requests", log_lba.size(), 0);

        // Mount while READY with a dirty sector: no write-back, full reload of track 5.
        pulse_we(5'd2);
        clear_logs();
        pulse_mount();
        wait_rr(1'b0, 10, "s3b_busy");
        wait_rr(1'b1, 3000, "s3b_ready");
        add_reads(84, 21);
        compare_log("s3b");

        // Scenario 4: mount during the read of sector 7 of track 6.
        clear_logs();
        track_req = 6'd6;
        k = 0;
        while (log_lba.size() < 8 && k < 2000) begin
            @(negedge clk32);
            k++;
        end
        check("s4_reached_sector7", log_lba.size() >= 8, 1'b1);
        pulse_mount();
        wait_rr(1'b1, 3000, "s4_ready");
        check("s4_track", track, 6'd6);
        add_reads(105, 8);
        add_reads(105, 21);
        compare_log("s4");

        // Scenario 5: track 35 bounds, then read-only writes and motor stop.
        clear_logs();
        retrack(6'd35, "s5");
        check("s5_track", track, 6'd35);
        add_reads(666, 17);
        compare_log("s5");
        clear_logs();
        wr_snap = wr_cycles;
        img_readonly = 1'b1;
        pulse_we(5'd0);
        pulse_we(5'd16);
        mtr = 1'b0;
        repeat (60) @(negedge clk32);
        check("s5_ro_requests", log_lba.size(), 0);
        check("s5_ro_wr_cycles", wr_cycles - wr_snap, 0);
        check("s5_ro_ready", ram_ready, 1'b1);
        mtr = 1'b1;
        img_readonly = 1'b0;

        // Scenario 6: off-image request leaves the buffer invalid with no traffic.
        clear_logs();
        track_req = 6'd0;
        wait_rr(1'b0, 100, "s6_busy");
        repeat (60) @(negedge clk32);
        check("s6_ready", ram_ready, 1'b0);
        check("s6_requests", log_lba.size(), 0);

        check("rd_wr_overlap", overlap, 0);
        check("addr_unstable", unstable, 0);
`ifdef C1541_WRITEBACK_EN
        check("total_writes", total_wr, 2);
`else
        check("total_writes", total_wr, 0);
        check("wr_cycles", wr_cycles, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
